// File: rtl/updn_cnt_fsm.sv
// updn_cnt_fsm: up/down counter with a load input and a SLEEP/CNTUP/CNTDN/OVF state machine.
// At a limit it either locks in OVF with a sticky flag, or wraps and pulses the flag for one cycle.
module updn_cnt_fsm #(
  parameter int WIDTH = 4,
  parameter int TOP = 2**WIDTH-1,
  parameter bit WRAP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             h_l,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             ovflw,
  output logic             unflw,
  output logic [1:0]       st
);
  typedef enum logic [1:0] {SLEEP = 2'b00, CNTUP = 2'b01, CNTDN = 2'b10, OVF = 2'b11} state_t;
  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);
  state_t state, state_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic ovflw_nx, unflw_nx;
  assign st = state;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SLEEP;
      cnt   <= '0;
      ovflw <= 1'b0;
      unflw <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ovflw <= ovflw_nx;
      unflw <= unflw_nx;
    end
  end
  // Flags default low: they are only held while locked in OVF, so a wrap produces a one-cycle pulse.
  always_comb begin
    state_nx = SLEEP;
    cnt_nx   = cnt;
    ovflw_nx = 1'b0;
    unflw_nx = 1'b0;
    if (ld) begin
      cnt_nx = ld_val > TOP_V ? TOP_V : ld_val;
    end else if (state == OVF) begin
      if (!clr_ovf && !WRAP) begin
        state_nx = OVF;
        ovflw_nx = ovflw;
        unflw_nx = unflw;
      end
    end else if (act && h_l) begin
      ovflw_nx = cnt >= TOP_V;
      state_nx = cnt < TOP_V || WRAP ? CNTUP : OVF;
      cnt_nx   = cnt < TOP_V ? cnt + WIDTH'(1) : (WRAP ? '0 : cnt);
    end else if (act) begin
      unflw_nx = cnt == '0;
      state_nx = cnt != '0 || WRAP ? CNTDN : OVF;
      cnt_nx   = cnt != '0 ? cnt - WIDTH'(1) : (WRAP ? TOP_V : cnt);
    end
  end
endmodule

// File: tb/tb_updn_cnt_fsm.sv
// tb_updn_cnt_fsm: drives a locking (TOP=15) and a wrapping (TOP=9) counter in lockstep
// through directed scenarios and random traffic, comparing both against an arithmetic model.
module tb_updn_cnt_fsm;
  logic clk = 1'b0, rst = 1'b0, act = 1'b0, h_l = 1'b0, ld = 1'b0, clr_ovf = 1'b0;
  logic [3:0] ld_val = '0;
  logic [3:0] cnt0, cnt1;
  logic ov0, un0, ov1, un1;
  logic [1:0] st0, st1;
  int passed = 0, total = 0;

  typedef struct {int c; int s; bit o; bit u;} m_t;
  m_t m0, m1;

  updn_cnt_fsm u0 (
    .clk(clk), .rst(rst), .act(act), .h_l(h_l), .ld(ld), .ld_val(ld_val),
    .clr_ovf(clr_ovf), .cnt(cnt0), .ovflw(ov0), .unflw(un0), .st(st0)
  );
  updn_cnt_fsm #(.WIDTH(4), .TOP(9), .WRAP(1'b1)) u1 (
    .clk(clk), .rst(rst), .act(act), .h_l(h_l), .ld(ld), .ld_val(ld_val),
    .clr_ovf(clr_ovf), .cnt(cnt1), .ovflw(ov1), .unflw(un1), .st(st1)
  );

  always #5 clk = ~clk;

  // States as plain numbers: 0 sleep, 1 up, 2 down, 3 locked overflow.
  function automatic m_t nxt(m_t m, int top, bit wrap);
    m_t r = m;
    r.o = 1'b0;
    r.u = 1'b0;
    r.s = 0;
    if (ld) r.c = (int'(ld_val) > top) ? top : int'(ld_val);
    else if (m.s == 3) begin
      if (!clr_ovf) begin
        r.s = 3;
        r.o = m.o;
        r.u = m.u;
      end
    end else if (act && h_l) begin
      if (m.c == top && !wrap) begin r.s = 3; r.o = 1'b1; end
      else begin r.s = 1; r.o = (m.c == top); r.c = (m.c + 1) % (top + 1); end
    end else if (act) begin
      if (m.c == 0 && !wrap) begin r.s = 3; r.u = 1'b1; end
      else begin r.s = 2; r.u = (m.c == 0); r.c = (m.c + top) % (top + 1); end
    end
    return r;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
  endtask

  task automatic cmp_all;
    chk("cnt0", int'(cnt0), m0.c);
    chk("st0", int'(st0), m0.s);
    chk("ovflw0", int'(ov0), int'(m0.o));
    chk("unflw0", int'(un0), int'(m0.u));
    chk("cnt1", int'(cnt1), m1.c);
    chk("st1", int'(st1), m1.s);
    chk("ovflw1", int'(ov1), int'(m1.o));
    chk("unflw1", int'(un1), int'(m1.u));
    chk("excl", int'((ov0 && un0) || (ov1 && un1)), 0);
  endtask

  task automatic tick;
    m0 = nxt(m0, 15, 1'b0);
    m1 = nxt(m1, 9, 1'b1);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  // Pulses reset away from any clock edge and checks the outputs cleared without a clock.
  task automatic do_reset;
    rst = 1'b0;
    #1;
    m0 = '{0, 0, 1'b0, 1'b0};
    m1 = '{0, 0, 1'b0, 1'b0};
    cmp_all();
    rst = 1'b1;
  endtask

  task automatic set_in(bit a, bit d, bit l, int lv, bit c);
    act = a;
    h_l = d;
    ld = l;
    ld_val = 4'(lv);
    clr_ovf = c;
  endtask

  initial begin
    m0 = '{0, 0, 1'b0, 1'b0};
    m1 = '{0, 0, 1'b0, 1'b0};
    @(posedge clk);
    #3;
    do_reset();
    // Count up to the top and lock; further activity ignored.
    set_in(1, 1, 0, 0, 0);
    repeat (16) tick();
    chk("lock_st", int'(st0), 3);
    chk("lock_cnt", int'(cnt0), 15);
    repeat (2) tick();
    set_in(1, 0, 0, 0, 0);
    tick();
    chk("lock_hold", int'(cnt0), 15);
    set_in(0, 0, 0, 0, 1);
    tick();
    chk("clr_st", int'(st0), 0);
    // Down from zero locks with underflow, then clears.
    do_reset();
    set_in(1, 0, 0, 0, 0);
    tick();
    chk("unf_flag", int'(un0), 1);
    set_in(1, 0, 0, 0, 1);
    tick();
    set_in(1, 1, 0, 0, 0);
    tick();
    // Load 8 then wrap at TOP=9; out-of-range load clamps.
    set_in(0, 0, 1, 8, 0);
    tick();
    set_in(1, 1, 0, 0, 0);
    repeat (2) tick();
    chk("wrap_cnt", int'(cnt1), 0);
    chk("wrap_ov", int'(ov1), 1);
    tick();
    chk("wrap_pulse", int'(ov1), 0);
    set_in(0, 0, 1, 12, 0);
    tick();
    chk("clamp", int'(cnt1), 9);
    // Direction reversal every cycle from 5.
    set_in(0, 0, 1, 5, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1, (i % 2) == 0, 0, 0, 0);
      tick();
    end
    // Load and clear together while locked; load wins.
    set_in(0, 0, 1, 15, 0);
    tick();
    set_in(1, 1, 0, 0, 0);
    tick();
    set_in(1, 1, 1, 3, 1);
    tick();
    chk("ld_ovf", int'(cnt0), 3);
    set_in(1, 1, 0, 0, 0);
    repeat (3) tick();
    #2;
    do_reset();
    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
             $urandom_range(0, 15), $urandom_range(0, 7) == 0);
      tick();
      if ($urandom_range(0, 63) == 0) begin
        #2;
        do_reset();
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
